// File: rtl/synth_pkg.sv
// Shared definitions for the synth audio path: scheduler state encoding
// and default sizing of the sample scheduler.
package synth_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } sched_state_t;

    localparam int SAMPLE_W           = 24;
    localparam int SCHED_DEPTH        = 128;
    localparam int SCHED_PRIME_LEVEL  = 64;
    localparam int SCHED_MAX_INFLIGHT = 4;

endpackage

// File: rtl/sample_scheduler_if.sv
// Request/return handshake between the sample scheduler and the mixer pipeline.
// Signal names are seen from the scheduler side.
interface sample_scheduler_if
    import synth_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W
);
    logic             o_gen_req;
    logic             i_valid;
    logic [WIDTH-1:0] i_sample;

    modport master (output o_gen_req, input i_valid, input i_sample);
    modport slave  (input o_gen_req, output i_valid, output i_sample);

endinterface

// File: rtl/sample_ring.sv
// Register-array sample storage with one write port and a registered read port.
// Pointer wrap is owned by the caller; rclr zeroes the read register.
module sample_ring
    import synth_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = SCHED_DEPTH
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    input  logic                     rclr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rdata <= '0;
        end else if (rclr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sample_scheduler.sv
// Credit-limited sample requester and ring-buffered DAC feeder.
//   state | meaning
//   IDLE  | stopped, buffer empty, nothing in flight
//   PRIME | requesting, ticks ignored until PRIME_LEVEL samples are buffered
//   RUN   | requesting, one sample released per tick
//   FLUSH | draining in-flight returns, buffer cleared
module sample_scheduler
    import synth_pkg::*;
#(
    parameter int WIDTH        = SAMPLE_W,
    parameter int DEPTH        = SCHED_DEPTH,
    parameter int PRIME_LEVEL  = SCHED_PRIME_LEVEL,
    parameter int MAX_INFLIGHT = SCHED_MAX_INFLIGHT
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       i_enable,
    input  logic                       i_tick,
    sample_scheduler_if.master         gen,
    output logic [WIDTH-1:0]           o_dac_sample,
    output logic                       o_dac_strobe,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic                       o_underrun,
    output logic [15:0]                o_underrun_cnt,
    output logic                       o_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_INFLIGHT + 1);

    sched_state_t    state;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [LW-1:0]   count;
    logic [OW-1:0]   outstanding;

    logic            run_active;
    logic            flush_entry;
    logic            accept;
    logic            push;
    logic            pop;
    logic            tick_empty;
    logic            req_ok;
    logic [31:0]     occupancy;
    logic [31:0]     inflight;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // The request issued this cycle is already committed, so it counts as in flight.
    always_comb begin
        run_active  = (state == PRIME || state == RUN) && i_enable;
        flush_entry = (state == PRIME || state == RUN) && !i_enable;
        accept      = gen.i_valid && (outstanding != '0);
        push        = accept && run_active;
        pop         = (state == RUN) && i_enable && i_tick && (count != '0);
        tick_empty  = (state == RUN) && i_enable && i_tick && (count == '0);
        inflight    = 32'(outstanding) + 32'(gen.o_gen_req);
        occupancy   = 32'(count) + inflight;
        req_ok      = run_active && (occupancy < 32'(DEPTH)) && (inflight < 32'(MAX_INFLIGHT));
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            outstanding    <= '0;
            gen.o_gen_req  <= 1'b0;
            o_dac_strobe   <= 1'b0;
            o_underrun     <= 1'b0;
            o_underrun_cnt <= '0;
            o_overflow     <= 1'b0;
        end else begin
            gen.o_gen_req <= req_ok;
            o_dac_strobe  <= pop;
            o_underrun    <= tick_empty;
            outstanding   <= outstanding + OW'(gen.o_gen_req) - OW'(accept);
            count         <= count + LW'(push) - LW'(pop);

            if (gen.i_valid && outstanding == '0) begin
                o_overflow <= 1'b1;
            end
            if (tick_empty && o_underrun_cnt != 16'hFFFF) begin
                o_underrun_cnt <= o_underrun_cnt + 16'd1;
            end
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end

            case (state)
                IDLE: begin
                    if (i_enable) state <= PRIME;
                end
                PRIME: begin
                    if (!i_enable) state <= FLUSH;
                    else if (count >= LW'(PRIME_LEVEL)) state <= RUN;
                end
                RUN: begin
                    if (!i_enable) state <= FLUSH;
                    else if (tick_empty) state <= PRIME;
                end
                FLUSH: begin
                    if (outstanding == '0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (flush_entry) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end
        end
    end

    assign o_level = count;

    sample_ring #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk   (clk),
        .n_rst (n_rst),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (gen.i_sample),
        .re    (pop),
        .raddr (rd_ptr),
        .rclr  (flush_entry),
        .rdata (o_dac_sample)
    );

endmodule
